// File: rtl/x300_rx_sample_capture.sv
// -----------------------------------------------------------------------------
// x300_rx_sample_capture
// Packetises the RX frontend's sample strobe/data into an AXI-stream for the
// radio core. Capture is gated by a settings-bus enable and rx_running. Each
// captured sample waits in a one-entry staging register until its packet
// position (tlast/eob) is known, then moves into a first-word fall-through
// FIFO. A flush into a full FIFO drops the sample and is reported through a
// sticky overflow flag and a saturating drop counter.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   set_stb/addr/data     settings bus (SR_BASE+0 = SPP, SR_BASE+1 = CTRL)
//   rx_running            radio RX run flag
//   rx_stb, rx_data       sample strobe and {I[31:16], Q[15:0]} sample
//   o_tdata/tlast/teob    output beat, packet end, burst end (with tlast)
//   o_tvalid, o_tready    stream handshake
//   overflow, ovf_count   sticky overflow flag, saturating drop count
// -----------------------------------------------------------------------------
module x300_rx_sample_capture #(
  parameter logic [7:0] SR_BASE   = 8'd240,
  parameter int         FIFO_SIZE = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        rx_running,
  input  logic        rx_stb,
  input  logic [31:0] rx_data,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_teob,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        overflow,
  output logic [15:0] ovf_count
);

  localparam int               LP_DEPTH     = 1 << FIFO_SIZE;
  localparam logic [7:0]       LP_ADDR_SPP  = SR_BASE;
  localparam logic [7:0]       LP_ADDR_CTRL = SR_BASE + 8'd1;
  // Occupancy counts the FIFO memory plus the output register, so the total
  // number of queued beats never exceeds 2**FIFO_SIZE.
  localparam logic [FIFO_SIZE:0] LP_CAP      = {1'b1, {FIFO_SIZE{1'b0}}};
  localparam logic [FIFO_SIZE:0] LP_CNT_ZERO = {(FIFO_SIZE+1){1'b0}};
  localparam logic [FIFO_SIZE:0] LP_CNT_ONE  = {{FIFO_SIZE{1'b0}}, 1'b1};
  localparam logic [FIFO_SIZE-1:0] LP_PTR_ONE = {{(FIFO_SIZE-1){1'b0}}, 1'b1};

  // Settings registers
  logic [15:0] r_spp;
  logic        r_enable;
  logic        r_clear;

  // Packet tracking and staging
  logic [15:0] r_idx;       // index the next captured sample will take
  logic [15:0] r_cur_spp;   // SPP latched at the start of the current packet
  logic        r_stg_valid;
  logic [31:0] r_stg_data;
  logic        r_stg_last;

  // FIFO
  logic [33:0]          r_mem [0:LP_DEPTH-1];
  logic [FIFO_SIZE-1:0] r_wr_ptr;
  logic [FIFO_SIZE-1:0] r_rd_ptr;
  logic [FIFO_SIZE:0]   r_count;
  logic                 r_out_valid;
  logic [31:0]          r_out_data;
  logic                 r_out_last;
  logic                 r_out_eob;

  // Status
  logic        r_overflow;
  logic [15:0] r_ovf_count;

  // Combinational control
  logic        w_run;
  logic        w_cap;
  logic        w_stop;
  logic        w_flush;
  logic        w_flush_last;
  logic        w_pop;
  logic [FIFO_SIZE:0] w_total;
  logic        w_full;
  logic        w_push;
  logic        w_drop;
  logic        w_load;
  logic [15:0] w_spp_eff;
  logic [15:0] w_cap_idx;
  logic [15:0] w_cap_spp;
  logic        w_cap_last;
  logic        w_unused_set_data;

  assign w_unused_set_data = &{1'b0, set_data[31:16]};

  assign w_run  = r_enable && rx_running;
  assign w_cap  = w_run && rx_stb;
  assign w_stop = !w_run;

  // The staged sample leaves when its packet end is known: it closed a
  // packet, a newer sample replaces it, or the stream stopped.
  assign w_flush      = r_stg_valid && (r_stg_last || w_cap || w_stop);
  assign w_flush_last = r_stg_last || w_stop;

  assign w_pop   = r_out_valid && o_tready;
  assign w_total = r_count + {{FIFO_SIZE{1'b0}}, r_out_valid};
  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign w_full  = (w_total == LP_CAP) && !w_pop;
  assign w_push  = w_flush && !w_full;
  assign w_drop  = w_flush && w_full;
  assign w_load  = (r_count != LP_CNT_ZERO) && (!r_out_valid || w_pop);

  assign w_spp_eff = (r_spp == 16'd0) ? 16'd1 : r_spp;
  // A drop restarts packetisation, so a sample captured alongside it opens
  // a new packet.
  assign w_cap_idx  = w_drop ? 16'd0 : r_idx;
  assign w_cap_spp  = (w_cap_idx == 16'd0) ? w_spp_eff : r_cur_spp;
  assign w_cap_last = (w_cap_idx == (w_cap_spp - 16'd1));

  // Settings-bus decode; the clear bit is a one-cycle strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spp    <= 16'd1024;
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      if (set_stb && (set_addr == LP_ADDR_SPP)) begin
        r_spp <= set_data[15:0];
      end else if (set_stb && (set_addr == LP_ADDR_CTRL)) begin
        r_enable <= set_data[0];
        r_clear  <= set_data[1];
      end
    end
  end

  // Packet index and per-packet SPP latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= 16'd0;
      r_cur_spp <= 16'd1;
    end else if (w_cap) begin
      r_idx <= w_cap_last ? 16'd0 : (w_cap_idx + 16'd1);
      if (w_cap_idx == 16'd0) begin
        r_cur_spp <= w_spp_eff;
      end
    end else if (w_stop || w_drop) begin
      r_idx <= 16'd0;
    end
  end

  // Staging register: holds the newest sample until its tlast is decided
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= 32'd0;
      r_stg_last  <= 1'b0;
    end else if (w_cap) begin
      r_stg_valid <= 1'b1;
      r_stg_data  <= rx_data;
      r_stg_last  <= w_cap_last;
    end else if (w_flush) begin
      r_stg_valid <= 1'b0;
      r_stg_last  <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_stop, w_flush_last, r_stg_data};
    end
  end

  // FIFO pointers and memory occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {FIFO_SIZE{1'b0}};
      r_rd_ptr <= {FIFO_SIZE{1'b0}};
      r_count  <= LP_CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: fall-through head of the FIFO, held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_last  <= 1'b0;
      r_out_eob   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      {r_out_eob, r_out_last, r_out_data} <= r_mem[r_rd_ptr];
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  // Overflow flag and drop counter; a drop outranks a pending clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_clear) begin
        r_ovf_count <= 16'd1;
      end else if (r_ovf_count != 16'hFFFF) begin
        r_ovf_count <= r_ovf_count + 16'd1;
      end
    end else if (r_clear) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= 16'd0;
    end
  end

  assign o_tdata   = r_out_data;
  assign o_tlast   = r_out_last;
  assign o_teob    = r_out_eob;
  assign o_tvalid  = r_out_valid;
  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;

endmodule
